// File: rtl/dec_scan_ctrl_pkg.sv
// Shared types and constants for the decoder scan controller.
package dec_scan_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    localparam int unsigned SEL_W      = 4;
    localparam int unsigned CODE_COUNT = 16;

endpackage

// File: rtl/dec_scan_ctrl_dwell_timer.sv
// Loadable down-counter with a zero flag; paces the timed scan.
module dwell_timer #(
    parameter int unsigned DWELL_W = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               load,
    input  logic [DWELL_W-1:0] load_val,
    input  logic               dec,
    output logic [DWELL_W-1:0] cnt,
    output logic               zero
);

    // Load has priority over decrement; the count saturates at zero.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_val;
        end else if (dec && (cnt != '0)) begin
            cnt <= cnt - DWELL_W'(1);
        end
    end

    assign zero = (cnt == '0);

endmodule

// File: rtl/dec_scan_ctrl.sv
// Scan controller that walks a 4-to-16 decoder select code from first to last,
// advancing either on a dwell timer or on manual step pulses.
module dec_scan_ctrl
    import dec_scan_ctrl_pkg::*;
#(
    parameter int unsigned DWELL_W = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic               stop,
    input  logic               step_mode,
    input  logic               step,
    input  logic [SEL_W-1:0]   first,
    input  logic [SEL_W-1:0]   last,
    input  logic [DWELL_W-1:0] dwell,
    output logic               i0,
    output logic               i1,
    output logic               i2,
    output logic               i3,
    output logic               EN,
    output logic               busy,
    output logic               done
);

    state_t             state, state_n;
    logic [SEL_W-1:0]   sel, sel_n;
    logic               en_n, busy_n, done_n;

    // Scan configuration captured at launch
    logic [SEL_W-1:0]   last_q;
    logic [DWELL_W-1:0] dwell_q;
    logic               step_q;
    logic               cfg_load;

    logic               tmr_load;
    logic [DWELL_W-1:0] tmr_load_val;
    logic               tmr_dec;
    logic [DWELL_W-1:0] tmr_cnt;
    logic               tmr_zero;
    logic               advance;

    dwell_timer #(
        .DWELL_W (DWELL_W)
    ) u_dwell_timer (
        .clk      (clk),
        .rst      (rst),
        .load     (tmr_load),
        .load_val (tmr_load_val),
        .dec      (tmr_dec),
        .cnt      (tmr_cnt),
        .zero     (tmr_zero)
    );

    // State, select code, registered outputs and launch-time configuration
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            sel     <= '0;
            EN      <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;
            last_q  <= '0;
            dwell_q <= '0;
            step_q  <= 1'b0;
        end else begin
            state <= state_n;
            sel   <= sel_n;
            EN    <= en_n;
            busy  <= busy_n;
            done  <= done_n;
            if (cfg_load) begin
                last_q  <= last;
                dwell_q <= dwell;
                step_q  <= step_mode;
            end
        end
    end

    // Next-state, next-output and timer control
    always_comb begin
        state_n      = state;
        sel_n        = sel;
        en_n         = EN;
        busy_n       = busy;
        done_n       = 1'b0;
        cfg_load     = 1'b0;
        tmr_load     = 1'b0;
        tmr_load_val = dwell_q;
        tmr_dec      = 1'b0;
        advance      = step_q ? step : tmr_zero;

        unique case (state)
            IDLE: begin
                en_n   = 1'b0;
                busy_n = 1'b0;
                // stop is deliberately not looked at here
                if (start) begin
                    cfg_load     = 1'b1;
                    sel_n        = first;
                    tmr_load     = 1'b1;
                    tmr_load_val = dwell;
                    en_n         = 1'b1;
                    busy_n       = 1'b1;
                    state_n      = RUN;
                end
            end
            RUN: begin
                if (stop) begin
                    en_n    = 1'b0;
                    busy_n  = 1'b0;
                    state_n = IDLE;
                end else if (advance) begin
                    if (sel == last_q) begin
                        en_n    = 1'b0;
                        busy_n  = 1'b0;
                        done_n  = 1'b1;
                        state_n = DONE;
                    end else begin
                        sel_n    = SEL_W'((32'(sel) + 32'd1) % CODE_COUNT);
                        tmr_load = 1'b1;
                    end
                end else if (!step_q) begin
                    tmr_dec = 1'b1;
                end
            end
            DONE: begin
                en_n    = 1'b0;
                busy_n  = 1'b0;
                state_n = IDLE;
            end
            default: begin
                en_n    = 1'b0;
                busy_n  = 1'b0;
                state_n = IDLE;
            end
        endcase
    end

    assign i0 = sel[0];
    assign i1 = sel[1];
    assign i2 = sel[2];
    assign i3 = sel[3];

endmodule

// File: tb/tb_dec_scan_ctrl.sv
// Scoreboard bench for dec_scan_ctrl: expected per-cycle outputs are queued as
// stimulus is driven and compared one entry per clock.
module tb_dec_scan_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic       start, stop, step_mode, step;
    logic [3:0] first, last;
    logic [3:0] dwell;
    logic       i0, i1, i2, i3, EN, busy, done;

    int unsigned checks = 0;
    int unsigned errors = 0;

    // Entry layout: {EN, busy, done, sel[3:0]}
    logic [6:0] exp_q[$];
    logic [6:0] obs;
    logic [15:0] dec_d;

    dec_scan_ctrl #(
        .DWELL_W (4)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .stop      (stop),
        .step_mode (step_mode),
        .step      (step),
        .first     (first),
        .last      (last),
        .dwell     (dwell),
        .i0        (i0),
        .i1        (i1),
        .i2        (i2),
        .i3        (i3),
        .EN        (EN),
        .busy      (busy),
        .done      (done)
    );

    always #5 clk = ~clk;

    assign obs = {EN, busy, done, i3, i2, i1, i0};

    // Downstream 4-to-16 decoder
    always_comb begin
        dec_d = '0;
        if (EN) dec_d[{i3, i2, i1, i0}] = 1'b1;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic logic [6:0] mk(input logic en, input logic bsy, input logic dn,
                                      input logic [3:0] s);
        return {en, bsy, dn, s};
    endfunction

    // Expected trace of a timed scan starting the cycle after launch
    task automatic push_scan(input logic [3:0] f, input logic [3:0] l, input logic [3:0] dw);
        logic [3:0] c;
        c = f;
        for (int unsigned n = 0; n < 16; n++) begin
            for (int unsigned k = 0; k <= 32'(dw); k++) exp_q.push_back(mk(1, 1, 0, c));
            if (c == l) break;
            c = c + 4'd1;
        end
        exp_q.push_back(mk(0, 0, 1, l));
        exp_q.push_back(mk(0, 0, 0, l));
    endtask

    task automatic tick(input string tag);
        logic [6:0]  e;
        logic [15:0] ed;
        @(negedge clk);
        if (exp_q.size() == 0) begin
            check({tag, "_underrun"}, 32'd1, 32'd0);
        end else begin
            e  = exp_q.pop_front();
            ed = '0;
            if (e[6]) ed[e[3:0]] = 1'b1;
            check(tag, 32'(obs), 32'(e));
            check({tag, "_dec"}, 32'(dec_d), 32'(ed));
        end
    endtask

    task automatic drain(input string tag);
        for (int unsigned n = 0; n < 200 && exp_q.size() > 0; n++) tick(tag);
        check({tag, "_drained"}, exp_q.size(), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst = 1'b1; start = 0; stop = 0; step_mode = 0; step = 0;
        first = '0; last = '0; dwell = '0;
        #1;
        check("reset_outputs", 32'(obs), 32'd0);
        @(negedge clk); @(negedge clk);
        rst = 1'b0;
        exp_q.push_back(mk(0, 0, 0, 0));
        tick("idle_after_reset");

        // Timed scan 2..5, dwell 1; config inputs scrambled after launch
        first = 4'd2; last = 4'd5; dwell = 4'd1; step_mode = 0; start = 1;
        push_scan(4'd2, 4'd5, 4'd1);
        tick("timed");
        start = 0; first = 4'd9; last = 4'd9; dwell = 4'd7; step_mode = 1;
        drain("timed");

        // Wrap-around scan 14,15,0,1 with no dwell
        first = 4'd14; last = 4'd1; dwell = 4'd0; step_mode = 0; start = 1;
        push_scan(4'd14, 4'd1, 4'd0);
        tick("wrap");
        start = 0;
        drain("wrap");

        // Manual step scan 0..2, steps three cycles apart
        first = 4'd0; last = 4'd2; dwell = 4'd0; step_mode = 1; start = 1;
        exp_q.push_back(mk(1, 1, 0, 0));
        tick("step");
        start = 0; step_mode = 0;
        for (int unsigned s = 0; s < 3; s++) begin
            for (int unsigned k = 0; k < 2; k++) begin
                step = 0;
                exp_q.push_back(mk(1, 1, 0, 4'(s)));
                tick("step_hold");
            end
            step = 1;
            if (s < 2) exp_q.push_back(mk(1, 1, 0, 4'(s + 1)));
            else       exp_q.push_back(mk(0, 0, 1, 4'd2));
            tick("step_adv");
            step = 0;
        end
        exp_q.push_back(mk(0, 0, 0, 4'd2));
        tick("step_idle");

        // Abort: stop on the last cycle of code 3 beats the advance; start mid-scan ignored
        first = 4'd0; last = 4'd15; dwell = 4'd1; step_mode = 0; start = 1;
        for (int unsigned c = 0; c < 4; c++) begin
            exp_q.push_back(mk(1, 1, 0, 4'(c)));
            exp_q.push_back(mk(1, 1, 0, 4'(c)));
        end
        tick("abort_run");
        start = 0;
        for (int unsigned n = 0; n < 7; n++) begin
            start = (n == 2);
            tick("abort_run");
        end
        start = 0; stop = 1;
        exp_q.push_back(mk(0, 0, 0, 4'd3));
        tick("abort_stop");
        stop = 0;
        for (int unsigned n = 0; n < 3; n++) begin
            exp_q.push_back(mk(0, 0, 0, 4'd3));
            tick("abort_quiet");
        end

        // One-code scan at 7 launched with start and stop together
        first = 4'd7; last = 4'd7; dwell = 4'd2; step_mode = 0; start = 1; stop = 1;
        push_scan(4'd7, 4'd7, 4'd2);
        tick("single");
        start = 0; stop = 0;
        drain("single");

        // Asynchronous reset in the middle of a scan
        first = 4'd2; last = 4'd5; dwell = 4'd3; step_mode = 0; start = 1;
        push_scan(4'd2, 4'd5, 4'd3);
        tick("pre_arst");
        start = 0;
        for (int unsigned n = 0; n < 4; n++) tick("pre_arst");
        @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        check("arst_outputs", 32'(obs), 32'd0);
        exp_q.delete();
        @(negedge clk);
        rst = 1'b0;
        exp_q.push_back(mk(0, 0, 0, 0));
        tick("arst_idle");

        // First launch after reset
        first = 4'd1; last = 4'd2; dwell = 4'd0; step_mode = 0; start = 1;
        push_scan(4'd1, 4'd2, 4'd0);
        tick("post_arst");
        start = 0;
        drain("post_arst");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
